// File: rtl/fft_reorder_pkg.sv
// ----------------------------------------------------------------------------
// fft_reorder_pkg
//   Shared FFT definitions: default frame length, address width and sample
//   part width, plus the bit-reversal helper used by the reorder buffer and
//   the pipeline stages.
//
//   Contents:
//     FFT_N      default frame length in samples
//     FFT_LOG2N  default address width (log2 of FFT_N)
//     FFT_WIDTH  default width of each real / imaginary sample part
//     bitrev()   reverses the low 'bits' bits of 'value'
// ----------------------------------------------------------------------------
package fft_reorder_pkg;

    localparam int FFT_N     = 32;
    localparam int FFT_LOG2N = 5;
    localparam int FFT_WIDTH = 19;

    // Shift the low 'bits' bits of value out LSB-first into the result, so
    // the first bit shifted in ends up as the MSB of the reversed field.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int bits);
        logic [31:0] v;
        logic [31:0] result;
        v      = value;
        result = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < bits) begin
                result = {result[30:0], v[0]};
                v      = {1'b0, v[31:1]};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// ----------------------------------------------------------------------------
// reorder_bank
//   One N-entry complex sample bank with a single write port and a
//   combinational (asynchronous) read port. Contents are not reset; the
//   surrounding logic tracks validity with a per-bank full flag.
//
//   Ports:
//     clk    in   sole clock, writes on the rising edge
//     we     in   write enable
//     waddr  in   LOG2N-bit write address
//     wdata  in   2*WIDTH-bit packed {real, imag} write data
//     raddr  in   LOG2N-bit read address
//     rdata  out  2*WIDTH-bit packed {real, imag} entry at raddr
// ----------------------------------------------------------------------------
module reorder_bank
    import fft_reorder_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [LOG2N-1:0]     waddr,
    input  logic [2*WIDTH-1:0]   wdata,
    input  logic [LOG2N-1:0]     raddr,
    output logic [2*WIDTH-1:0]   rdata
);

    logic [2*WIDTH-1:0] mem_q [N];
    logic [2*WIDTH-1:0] mem_d [N];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_reorder.sv
// ----------------------------------------------------------------------------
// fft_reorder
//   Converts a stream of FFT samples arriving in bit-reversed frame order into
//   natural frame order. Two ping-pong banks let one frame be written while the
//   previous one drains, so full-rate streaming never stalls.
//
//   Ports:
//     clk        in   sole clock, rising edge
//     rst        in   synchronous active-high reset
//     in_valid   in   input sample present
//     in_ready   out  input sample accepted this cycle when in_valid is high
//     in_r/in_i  in   input sample real / imaginary parts (WIDTH each)
//     out_valid  out  output sample present (natural order)
//     out_ready  in   downstream accepts the output sample
//     out_r/out_i out output sample real / imaginary parts (WIDTH each)
//     out_last   out  high with output index N-1 of each frame
// ----------------------------------------------------------------------------
module fft_reorder
    import fft_reorder_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic [WIDTH-1:0] out_i,
    output logic             out_last
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;

    logic             in_fire;
    logic             out_fire;
    logic             wr_last;
    logic             rd_last;
    logic [LOG2N-1:0] wr_addr;
    logic [2*WIDTH-1:0] rdata0;
    logic [2*WIDTH-1:0] rdata1;

    // Handshake and status: the write side stalls only when the bank it is
    // about to fill still holds an undrained frame.
    always_comb begin
        in_ready  = !full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        wr_last   = in_fire && (wr_cnt_q == LAST_IDX);
        rd_last   = out_fire && (rd_cnt_q == LAST_IDX);
        out_last  = out_valid && (rd_cnt_q == LAST_IDX);
        wr_addr   = LOG2N'(bitrev(32'(wr_cnt_q), LOG2N));
    end

    // Next-state logic. A last write and a last read in the same cycle always
    // target different banks (a bank being read is full, so it cannot be the
    // write bank), so both flag updates apply independently.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        if (in_fire) begin
            wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (out_fire) begin
            rd_cnt_d = rd_last ? '0 : rd_cnt_q + 1'b1;
            if (rd_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
        end
    end

    reorder_bank #(.N(N), .LOG2N(LOG2N), .WIDTH(WIDTH)) u_bank0 (
        .clk   (clk),
        .we    (in_fire && !wr_bank_q),
        .waddr (wr_addr),
        .wdata ({in_r, in_i}),
        .raddr (rd_cnt_q),
        .rdata (rdata0)
    );

    reorder_bank #(.N(N), .LOG2N(LOG2N), .WIDTH(WIDTH)) u_bank1 (
        .clk   (clk),
        .we    (in_fire && wr_bank_q),
        .waddr (wr_addr),
        .wdata ({in_r, in_i}),
        .raddr (rd_cnt_q),
        .rdata (rdata1)
    );

    // Read data is purely a function of registered state, so it holds
    // steady whenever the output is stalled.
    always_comb begin
        {out_r, out_i} = rd_bank_q ? rdata1 : rdata0;
    end

endmodule

// File: tb/tb_fft_reorder.sv
// ----------------------------------------------------------------------------
// tb_fft_reorder
//   Self-checking bench for fft_reorder. A frame-level reference model
//   collects each bit-reversed input frame, reorders it into natural order
//   when complete and queues the result; handshake expectations follow from
//   how many complete frames are buffered.
// ----------------------------------------------------------------------------
module tb_fft_reorder;

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int W     = 19;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_r = '0;
    logic [W-1:0] in_i = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_r;
    logic [W-1:0] out_i;
    logic         out_last;

    fft_reorder #(.N(N), .LOG2N(LOG2N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;
    int dutAccepts = 0;

    // Reference model state
    logic [2*W-1:0] frameBuf [N];
    int             inIdx = 0;
    int             outIdx = 0;
    int             framesStored = 0;
    logic [2*W-1:0] expQ [$];

    function automatic int refBitrev(input int v);
        int r;
        int x;
        r = 0;
        x = v;
        for (int b = 0; b < LOG2N; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelClear();
        inIdx = 0;
        outIdx = 0;
        framesStored = 0;
        expQ.delete();
    endtask

    // One clock cycle: drive inputs, check DUT outputs against the model,
    // then advance the model with the transfers the model predicts.
    task automatic applyStimulus(input logic iv, input logic [W-1:0] r, input logic [W-1:0] i, input logic ordy);
        logic expInReady;
        logic expOutValid;
        logic inFire;
        logic outFire;
        in_valid  = iv;
        in_r      = r;
        in_i      = i;
        out_ready = ordy;
        #1;
        expInReady  = (framesStored < 2);
        expOutValid = (framesStored > 0);
        checkOutput("in_ready", 64'(in_ready), 64'(expInReady));
        checkOutput("out_valid", 64'(out_valid), 64'(expOutValid));
        checkOutput("out_last", 64'(out_last), 64'(expOutValid && (outIdx == N - 1)));
        if (expOutValid && expQ.size() > 0) begin
            checkOutput("out_data", 64'({out_r, out_i}), 64'(expQ[0]));
        end
        if (iv && in_ready) dutAccepts++;
        inFire  = iv && expInReady;
        outFire = ordy && expOutValid;
        @(posedge clk);
        if (outFire) begin
            void'(expQ.pop_front());
            outIdx++;
            if (outIdx == N) begin
                outIdx = 0;
                framesStored--;
            end
        end
        if (inFire) begin
            frameBuf[inIdx] = {r, i};
            inIdx++;
            if (inIdx == N) begin
                for (int j = 0; j < N; j++) expQ.push_back(frameBuf[refBitrev(j)]);
                inIdx = 0;
                framesStored++;
            end
        end
        @(negedge clk);
    endtask

    task automatic applyReset(input int cycles);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelClear();
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_last", 64'(out_last), 64'd0);
    endtask

    task automatic drain(input int cycles);
        for (int c = 0; c < cycles; c++) applyStimulus(1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        int br;
        @(negedge clk);
        applyReset(2);

        // Directed frame: input k carries bitrev(k), so outputs count upward.
        for (int k = 0; k < N; k++) begin
            br = refBitrev(k);
            applyStimulus(1'b1, W'(br), W'(-br), 1'b1);
        end
        #1;
        checkOutput("latency_valid", 64'(out_valid), 64'd1);
        checkOutput("first_out_r", 64'(out_r), 64'd0);
        drain(N + 2);

        // Four back-to-back frames at full rate, then flush.
        for (int c = 0; c < 4 * N; c++) applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b1);
        drain(2 * N + 2);

        // Output stalled for 70 cycles while input keeps offering samples.
        dutAccepts = 0;
        for (int c = 0; c < 70; c++) applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b0);
        checkOutput("hold_accepts", 64'(dutAccepts), 64'd64);
        drain(2 * N + 4);

        // Random valid / ready at roughly 50 percent.
        for (int c = 0; c < 800; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        drain(2 * N + 4);

        // Reset mid-frame with one complete frame buffered.
        for (int c = 0; c < N + 17; c++) applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b0);
        applyReset(1);
        for (int k = 0; k < N; k++) begin
            br = refBitrev(k);
            applyStimulus(1'b1, W'(br + 100), W'(-br), 1'b1);
        end
        #1;
        checkOutput("post_rst_first", 64'(out_r), 64'd100);
        drain(N + 2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/fft_reorder.md
FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001: Parameter N, default 32, is the FFT frame length in samples.
REQ-002: Parameter LOG2N, default 5, is the address width (log2 N).
REQ-003: Parameter WIDTH, default 19, is the width of each real and imaginary sample part.
REQ-004: clk  input  1  sole clock; all state updates on rising edge.
REQ-005: rst  input  1  reset, synchronous and active-high.
REQ-006: in_valid  input  1  input sample present, in bit-reversed frame order.
REQ-007: in_ready  output  1  block can accept an input sample this cycle.
REQ-008: in_r, in_i  input  WIDTH each  input sample real and imaginary parts.
REQ-009: out_valid  output  1  output sample present, in natural frame order.
REQ-010: out_ready  input  1  downstream accepts the output sample this cycle.
REQ-011: out_r, out_i  output  WIDTH each  output sample real and imaginary parts.
REQ-012: out_last  output  1  high with output index N-1 of a frame.

Function
REQ-013: An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-014: Storage SHALL be two ping-pong banks of N complex entries, each bank with a full flag.
REQ-015: Input transfer k (k = 0..N-1) of a frame SHALL write entry bitrev(k) of the write bank; bitrev reverses the LOG2N bits.
REQ-016: The write counter SHALL wrap from N-1 to 0; on that transfer the write bank full flag SHALL set and the write bank pointer SHALL toggle.
REQ-017: in_ready SHALL equal NOT full of the current write bank.
REQ-018: out_valid SHALL equal full of the current read bank.
REQ-019: out_r/out_i SHALL be the read-bank entry at the read counter, combinationally; they SHALL hold while out_valid is high and out_ready is low.
REQ-020: Output transfer j SHALL present entry j; the read counter SHALL wrap from N-1 to 0, clearing the read bank full flag and toggling the read bank pointer.
REQ-021: out_last SHALL equal out_valid AND (read counter == N-1).
REQ-022: Latency SHALL be 1 cycle: out_valid rises on the cycle after the frame's last input transfer if the read bank was empty.
REQ-023: A frame completing on input while the other bank drains SHALL be stored without stall; in_ready SHALL drop only when both banks are full.
REQ-024: When the last input transfer into a bank and the last output transfer out of the other bank occur in the same cycle, both flag updates SHALL take effect; no sample SHALL be lost or duplicated.
REQ-025: Full-rate streaming (in_valid and out_ready held high) SHALL sustain one sample per cycle indefinitely.
REQ-026: No output transfer SHALL be attempted while out_valid is low; out_ready is then ignored.

Reset
REQ-027: While rst is high, the counters, the bank pointers and both full flags SHALL clear at the next edge; in_ready SHALL go 1, out_valid 0 and out_last 0.
REQ-028: Bank contents SHALL NOT need reset; out_r/out_i are don't-care while out_valid is 0.
REQ-029: Reset asserted mid-frame SHALL discard all partial and complete frames; the first input after reset is index 0 of a new frame.

Structure
REQ-030: N, LOG2N and WIDTH defaults and the bitrev function SHALL live in a shared FFT package also used by the pipeline stages.
REQ-031: One sub-module, reorder_bank, SHALL implement a single N x 2*WIDTH register bank with one write port and one combinational read port, instantiated twice.

Verification
REQ-032: One frame with input sample k carrying in_r = bitrev(k), in_i = -bitrev(k), out_ready=1 -> out_r = 0,1,...,31 in order, out_valid rising exactly 1 cycle after the 32nd input, out_last only on value 31.
REQ-033: Back-to-back frames at full rate for 4 frames -> in_ready stays 1, 128 outputs with no gaps after the first frame, each frame in natural order.
REQ-034: out_ready=0 for 70 cycles while sending frames -> in_ready drops after exactly 64 accepted samples; out_r/out_i stable throughout; the next draining resumes at index 0 with no loss.
REQ-035: out_ready toggled randomly at 50% -> output sequence equals the golden natural-order sequence, and out_r/out_i are unchanged between cycles in which valid is high and ready is low.
REQ-036: rst pulsed for 1 cycle after 17 inputs of a frame, with bank 1 full -> out_valid=0 and in_ready=1 next cycle; a fresh frame then emerges correctly with no stale data.
REQ-037: Simultaneous last-write and last-read cycle forced -> flags consistent, the next frame is output immediately after.
